flg_match_offset_stream: RTL and testbench
==========================================

// Module: flg_match_offset_stream
// PURPOSE
//  Streaming successor of the fixed-32 single-pair flag offset cell. Accepts one
//  activation/weight sparsity-flag vector pair per handshake, walks every position where
//  both flags are set (LSB first), emits one beat per match.
//  Each beat carries the compressed-buffer offsets (popcount of flags strictly below the
//  match) for act and wei. Sits between the flag FIFOs and the PEC MAC operand fetch.
// PARAMETERS
//  FLG_WIDTH   32  flag vector width (channels per word), >=2
//  EMIT_EMPTY  1   1: a vector with zero matches emits one beat with out_none=1; 0: emits nothing
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          asynchronous active-low reset
//  clr        in   1          sync flush: drop current vector and output beat
//  in_valid   in   1          flag pair valid
//  in_ready   out  1          pair accepted when in_valid&&in_ready
//  flg_act    in   FLG_WIDTH  activation nonzero flags
//  flg_wei    in   FLG_WIDTH  weight nonzero flags
//  out_valid  out  1          match beat valid
//  out_ready  in   1          downstream accepts beat
//  ofs_act    out  OFS_W      popcount(flg_act below match pos)
//  ofs_wei    out  OFS_W      popcount(flg_wei below match pos)
//  out_pos    out  OFS_W      channel index of match
//  out_last   out  1          final beat of this vector
//  out_none   out  1          vector had no match (ofs/pos = 0)
//  out_cnt    out  CNT_W      total matches in vector, held for whole vector
// BEHAVIOUR
//  - OFS_W=$clog2(FLG_WIDTH); CNT_W=$clog2(FLG_WIDTH+1); all arithmetic unsigned, no overflow.
//  - Reset: state=IDLE, in_ready=1, out_valid=0, all other outputs 0, working regs 0.
//  - FSM IDLE/SCAN. IDLE: in_ready=1; accept -> latch act_r, wei_r, rem_r=act&wei,
//    cnt_r=popcount(act&wei); go SCAN.
//  - SCAN: sel=lowest set bit of rem_r; beat computed combinationally, loaded into output
//    reg when !out_valid||out_ready; on load rem_r clears sel.
//  - Latency: accept on edge E0 -> first out_valid after edge E0+1; 1 beat/cycle with out_ready=1.
//  - out_last=1 when sel is the only bit left in rem_r; vector done on that load.
//  - in_ready=1 in SCAN during the cycle the last beat loads; a pair accepted then is scanned
//    next cycle: back-to-back vectors with no bubble.
//  - rem_r==0 in SCAN (zero matches): EMIT_EMPTY=1 loads one beat out_none=1,out_last=1,out_cnt=0;
//    EMIT_EMPTY=0 returns to IDLE, no beat, in_ready=1 that cycle.
//  - out_valid held until out_ready; all out_* stable while out_valid&&!out_ready.
//  - clr: next edge -> IDLE, out_valid=0, rem_r=0; clr wins over a simultaneous accept.
//  - rst_n low mid-vector: immediate return to reset state, beats in flight lost.
// STRUCTURE
//  - flg_pkg: OFS_W/CNT_W helper functions, FSM state enum.
//  - Sub-module flg_lsb_sel: one-hot lowest set bit, index, below-mask, "single bit" flag.
//  - Popcounts of act_r&below and wei_r&below: adder trees in the top level.
// TESTING
//  1 act=0x000000F5 wei=0x00000034 -> 3 beats pos 2/4/5, ofs_act 1/2/3, ofs_wei 0/1/2, last on 3rd, cnt=3
//  2 act=wei=0xFFFFFFFF -> 32 beats, ofs_act=ofs_wei=pos=0..31, last at 31, cnt=32
//  3 act=0xFFFF0000 wei=0x0000FFFF: EMIT_EMPTY=1 -> one beat none=1 last=1 cnt=0; EMIT_EMPTY=0 -> none
//  4 test1 with out_ready low 3 cycles after beat 1 -> beat 2 held stable, no loss or duplicate
//  5 two pairs in_valid back-to-back (0x1/0x1 then 0x3/0x2) -> beats pos0(last), pos1 ofs_act=1 ofs_wei=0 (last), no gap
//  6 clr, then rst_n low, each during beat 2 of test 2 -> out_valid=0 next edge, in_ready=1, next vector correct

Source files
------------

// File: rtl/flg_pkg.sv
// Shared helpers for the flag match offset stream: output width functions and FSM state.
package flg_pkg;

  function automatic int unsigned ofs_w(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/flg_lsb_sel.sv
// Lowest-set-bit selector: one-hot select, its index, mask of positions below it,
// and whether it is the only bit left in the vector.
module flg_lsb_sel #(
  parameter int unsigned W  = 32,
  parameter int unsigned IW = flg_pkg::ofs_w(W)
) (
  input  logic [W-1:0]  vec,
  output logic [W-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic [W-1:0]  below,
  output logic          single
);

  always_comb begin
    onehot = vec & (~vec + W'(1));
    below  = onehot - W'(1);
    single = (vec != '0) && ((vec & (vec - W'(1))) == '0);
    idx    = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (onehot[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/flg_match_offset_stream.sv
// Walks every position where both activation and weight flags are set (LSB first) and
// emits one beat per match carrying the compressed-buffer offsets for both operands.
module flg_match_offset_stream
  import flg_pkg::*;
#(
  parameter int unsigned FLG_WIDTH  = 32,
  parameter bit          EMIT_EMPTY = 1'b1,
  localparam int unsigned OFS_W     = ofs_w(FLG_WIDTH),
  localparam int unsigned CNT_W     = cnt_w(FLG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLG_WIDTH-1:0] flg_act,
  input  logic [FLG_WIDTH-1:0] flg_wei,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OFS_W-1:0]     ofs_act,
  output logic [OFS_W-1:0]     ofs_wei,
  output logic [OFS_W-1:0]     out_pos,
  output logic                 out_last,
  output logic                 out_none,
  output logic [CNT_W-1:0]     out_cnt
);

  state_e               state;
  logic [FLG_WIDTH-1:0] act_r;
  logic [FLG_WIDTH-1:0] wei_r;
  logic [FLG_WIDTH-1:0] rem_r;
  logic [CNT_W-1:0]     cnt_r;

  logic [FLG_WIDTH-1:0] sel_oh;
  logic [FLG_WIDTH-1:0] sel_below;
  logic [OFS_W-1:0]     sel_idx;
  logic                 sel_single;

  logic                 load_c;
  logic                 has_c;
  logic                 emit_c;
  logic                 done_c;
  logic                 accept_c;
  logic [OFS_W-1:0]     beat_oa_c;
  logic [OFS_W-1:0]     beat_ow_c;

  flg_lsb_sel #(
    .W  (FLG_WIDTH),
    .IW (OFS_W)
  ) u_sel (
    .vec    (rem_r),
    .onehot (sel_oh),
    .idx    (sel_idx),
    .below  (sel_below),
    .single (sel_single)
  );

  function automatic logic [CNT_W-1:0] popcnt(input logic [FLG_WIDTH-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < int'(FLG_WIDTH); i++) begin
      s = s + CNT_W'(v[i]);
    end
    return s;
  endfunction

  // Beat generation and vector completion; done_c opens in_ready for a back-to-back pair.
  always_comb begin
    load_c    = !out_valid || out_ready;
    has_c     = (rem_r != '0);
    beat_oa_c = OFS_W'(popcnt(act_r & sel_below));
    beat_ow_c = OFS_W'(popcnt(wei_r & sel_below));
    emit_c    = 1'b0;
    done_c    = 1'b0;
    if (state == ST_SCAN) begin
      if (has_c) begin
        emit_c = load_c;
        done_c = load_c && sel_single;
      end else if (EMIT_EMPTY) begin
        emit_c = load_c;
        done_c = load_c;
      end else begin
        done_c = 1'b1;
      end
    end
  end

  assign in_ready = (state == ST_IDLE) || done_c;
  assign accept_c = in_valid && in_ready && !clr;

  // FSM, working registers and registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      act_r     <= '0;
      wei_r     <= '0;
      rem_r     <= '0;
      cnt_r     <= '0;
      out_valid <= 1'b0;
      ofs_act   <= '0;
      ofs_wei   <= '0;
      out_pos   <= '0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
      out_cnt   <= '0;
    end else if (clr) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      rem_r     <= '0;
    end else begin
      if (load_c) begin
        out_valid <= emit_c;
        if (emit_c) begin
          if (has_c) begin
            ofs_act  <= beat_oa_c;
            ofs_wei  <= beat_ow_c;
            out_pos  <= sel_idx;
            out_last <= sel_single;
            out_none <= 1'b0;
            out_cnt  <= cnt_r;
          end else begin
            ofs_act  <= '0;
            ofs_wei  <= '0;
            out_pos  <= '0;
            out_last <= 1'b1;
            out_none <= 1'b1;
            out_cnt  <= '0;
          end
        end
      end
      if (emit_c && has_c) rem_r <= rem_r & ~sel_oh;
      if (accept_c) begin
        act_r <= flg_act;
        wei_r <= flg_wei;
        rem_r <= flg_act & flg_wei;
        cnt_r <= popcnt(flg_act & flg_wei);
        state <= ST_SCAN;
      end else if (done_c) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_flg_match_offset_stream.sv
// Self-checking bench: table of hand-computed vectors, directed handshake corner cases,
// and randomized traffic scored against a position-walking reference model.
module tb_flg_match_offset_stream;

  localparam int NRAND = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [31:0] flg_act = '0;
  logic [31:0] flg_wei = '0;

  logic in_valid0 = 1'b0, out_ready0 = 1'b1;
  logic in_ready0, out_valid0, out_last0, out_none0;
  logic [4:0] ofs_act0, ofs_wei0, out_pos0;
  logic [5:0] out_cnt0;

  logic in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic in_ready1, out_valid1, out_last1, out_none1;
  logic [4:0] ofs_act1, ofs_wei1, out_pos1;
  logic [5:0] out_cnt1;

  always #5 clk = ~clk;

  flg_match_offset_stream #(.FLG_WIDTH(32), .EMIT_EMPTY(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid0), .in_ready(in_ready0),
    .flg_act(flg_act), .flg_wei(flg_wei), .out_valid(out_valid0), .out_ready(out_ready0),
    .ofs_act(ofs_act0), .ofs_wei(ofs_wei0), .out_pos(out_pos0), .out_last(out_last0),
    .out_none(out_none0), .out_cnt(out_cnt0));

  flg_match_offset_stream #(.FLG_WIDTH(32), .EMIT_EMPTY(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid1), .in_ready(in_ready1),
    .flg_act(flg_act), .flg_wei(flg_wei), .out_valid(out_valid1), .out_ready(out_ready1),
    .ofs_act(ofs_act1), .ofs_wei(ofs_wei1), .out_pos(out_pos1), .out_last(out_last1),
    .out_none(out_none1), .out_cnt(out_cnt1));

  typedef struct packed {
    logic [4:0] pos;
    logic [4:0] oa;
    logic [4:0] ow;
    logic       last;
    logic       none;
    logic [5:0] cnt;
  } beat_t;

  typedef struct {
    logic [31:0] act;
    logic [31:0] wei;
    int nb;
    int cnt;
    int fpos, foa, fow, fnone;
    int lpos, loa, low;
  } vec_t;

  beat_t exp0[$], exp1[$], gen_q[$], obs0[$];
  int    obs_cyc0[$];
  int    checks = 0, failures = 0;
  int    done0 = 0, beats1 = 0, cycle_n = 0, acc_cyc0 = 0;
  bit    acc0, acc1, stall0;
  beat_t hold0;

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, req);
    end
  endtask

  task automatic chk_beat(input string name, input beat_t g, input beat_t e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got pos=%0d oa=%0d ow=%0d last=%0d none=%0d cnt=%0d expected pos=%0d oa=%0d ow=%0d last=%0d none=%0d cnt=%0d",
               name, g.pos, g.oa, g.ow, g.last, g.none, g.cnt, e.pos, e.oa, e.ow, e.last, e.none, e.cnt);
    end
  endtask

  // Reference: walk every channel, offsets are plain counts of set flags below the match.
  function automatic void model(input logic [31:0] a, input logic [31:0] w, input bit emit);
    int n, seen, ca, cw;
    beat_t b;
    gen_q.delete();
    n = 0;
    for (int p = 0; p < 32; p++) if (a[p] && w[p]) n++;
    seen = 0;
    for (int p = 0; p < 32; p++) begin
      if (a[p] && w[p]) begin
        ca = 0; cw = 0;
        for (int i = 0; i < p; i++) begin
          if (a[i]) ca++;
          if (w[i]) cw++;
        end
        seen++;
        b = '0;
        b.pos = 5'(p); b.oa = 5'(ca); b.ow = 5'(cw);
        b.last = (seen == n); b.cnt = 6'(n);
        gen_q.push_back(b);
      end
    end
    if (n == 0 && emit) begin
      b = '0; b.last = 1'b1; b.none = 1'b1;
      gen_q.push_back(b);
    end
  endfunction

  // One clock: sample/score at negedge, then return 1 time unit after the posedge.
  task automatic cyc();
    beat_t g, g1;
    @(negedge clk);
    acc0 = 1'b0; acc1 = 1'b0;
    if (!rst_n) begin
      exp0.delete(); exp1.delete(); stall0 = 1'b0;
    end else begin
      g  = beat_t'({out_pos0, ofs_act0, ofs_wei0, out_last0, out_none0, out_cnt0});
      g1 = beat_t'({out_pos1, ofs_act1, ofs_wei1, out_last1, out_none1, out_cnt1});
      if (stall0) begin
        chk("stall_valid", int'(out_valid0), 1);
        chk_beat("stall_hold", g, hold0);
      end
      if (out_valid0 && out_ready0) begin
        obs0.push_back(g); obs_cyc0.push_back(cycle_n);
        if (exp0.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat0: got pos=%0d none=%0d expected no beat", g.pos, g.none);
        end else chk_beat("beat0", g, exp0.pop_front());
        if (g.last) done0++;
      end
      if (out_valid1 && out_ready1) begin
        beats1++;
        if (exp1.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat1: got pos=%0d none=%0d expected no beat", g1.pos, g1.none);
        end else chk_beat("beat1", g1, exp1.pop_front());
      end
      stall0 = out_valid0 && !out_ready0 && !clr;
      hold0  = g;
      if (clr) begin
        exp0.delete(); exp1.delete();
      end else begin
        if (in_valid0 && in_ready0) begin
          acc0 = 1'b1; acc_cyc0 = cycle_n;
          model(flg_act, flg_wei, 1'b1);
          foreach (gen_q[i]) exp0.push_back(gen_q[i]);
        end
        if (in_valid1 && in_ready1) begin
          acc1 = 1'b1;
          model(flg_act, flg_wei, 1'b0);
          foreach (gen_q[i]) exp1.push_back(gen_q[i]);
        end
      end
    end
    @(posedge clk); #1;
    cycle_n++;
  endtask

  task automatic send0(input logic [31:0] a, input logic [31:0] w);
    int n;
    flg_act = a; flg_wei = w; in_valid0 = 1'b1; n = 0;
    do begin cyc(); n++; end while (!acc0 && n < 200);
    chk("accept0", int'(acc0), 1);
  endtask

  task automatic wait_done0(input int target);
    int n;
    n = 0;
    while (done0 < target && n < 500) begin cyc(); n++; end
    chk("done0_reached", done0, target);
  endtask

  task automatic wait_obs0(input int target);
    int n;
    n = 0;
    while (obs0.size() < target && n < 200) begin cyc(); n++; end
    chk("obs0_reached", obs0.size(), target);
  endtask

  vec_t tbl[7];

  initial begin
    int base, d, b1, n, sent, target;
    logic [31:0] ra, rw;

    tbl[0] = '{32'h000000F5, 32'h00000034, 3, 3, 2, 1, 0, 0, 5, 3, 2};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32, 0, 0, 0, 0, 31, 31, 31};
    tbl[2] = '{32'hFFFF0000, 32'h0000FFFF, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[3] = '{32'h80000000, 32'h80000001, 1, 1, 31, 0, 1, 0, 31, 0, 1};
    tbl[4] = '{32'h00000001, 32'h00000001, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{32'hAAAAAAAA, 32'hFFFFFFFF, 16, 16, 1, 0, 1, 0, 31, 15, 31};
    tbl[6] = '{32'h00000000, 32'h00000000, 1, 0, 0, 0, 0, 1, 0, 0, 0};

    #2;
    chk("rst_out_valid0", int'(out_valid0), 0);
    chk("rst_in_ready0", int'(in_ready0), 1);
    chk("rst_out_cnt0", int'(out_cnt0), 0);
    chk("rst_out_last0", int'(out_last0), 0);
    chk("rst_out_valid1", int'(out_valid1), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();

    foreach (tbl[r]) begin
      base = obs0.size(); d = done0;
      send0(tbl[r].act, tbl[r].wei);
      in_valid0 = 1'b0;
      wait_done0(d + 1);
      chk("tbl_nbeats", obs0.size() - base, tbl[r].nb);
      if (obs0.size() > base) begin
        chk("tbl_latency", obs_cyc0[base] - acc_cyc0, 2);
        chk("tbl_rate", obs_cyc0[obs0.size()-1] - obs_cyc0[base], tbl[r].nb - 1);
        chk("tbl_first_pos", int'(obs0[base].pos), tbl[r].fpos);
        chk("tbl_first_oa", int'(obs0[base].oa), tbl[r].foa);
        chk("tbl_first_ow", int'(obs0[base].ow), tbl[r].fow);
        chk("tbl_first_none", int'(obs0[base].none), tbl[r].fnone);
        chk("tbl_last_pos", int'(obs0[obs0.size()-1].pos), tbl[r].lpos);
        chk("tbl_last_oa", int'(obs0[obs0.size()-1].oa), tbl[r].loa);
        chk("tbl_last_ow", int'(obs0[obs0.size()-1].ow), tbl[r].low);
        chk("tbl_last_flag", int'(obs0[obs0.size()-1].last), 1);
        chk("tbl_cnt", int'(obs0[base].cnt), tbl[r].cnt);
      end
    end

    // Backpressure after the first beat of the 3-match vector.
    base = obs0.size(); d = done0;
    send0(32'h000000F5, 32'h00000034);
    in_valid0 = 1'b0;
    wait_obs0(base + 1);
    out_ready0 = 1'b0;
    repeat (3) cyc();
    out_ready0 = 1'b1;
    wait_done0(d + 1);
    chk("stall_nbeats", obs0.size() - base, 3);
    if (obs0.size() > base + 1) chk("stall_beat2_pos", int'(obs0[base+1].pos), 4);

    // Two pairs presented back-to-back.
    base = obs0.size(); d = done0;
    send0(32'h1, 32'h1);
    send0(32'h3, 32'h2);
    in_valid0 = 1'b0;
    wait_done0(d + 2);
    chk("b2b_nbeats", obs0.size() - base, 2);
    if (obs0.size() >= base + 2) begin
      chk("b2b_gap", obs_cyc0[base+1] - obs_cyc0[base], 1);
      chk("b2b_pos", int'(obs0[base+1].pos), 1);
      chk("b2b_oa", int'(obs0[base+1].oa), 1);
      chk("b2b_ow", int'(obs0[base+1].ow), 0);
    end

    // Synchronous flush during beat 2 of the full vector.
    base = obs0.size();
    send0(32'hFFFFFFFF, 32'hFFFFFFFF);
    in_valid0 = 1'b0;
    wait_obs0(base + 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_out_valid", int'(out_valid0), 0);
    chk("clr_in_ready", int'(in_ready0), 1);
    base = obs0.size(); d = done0;
    send0(32'h000000F5, 32'h00000034);
    in_valid0 = 1'b0;
    wait_done0(d + 1);
    chk("clr_next_nbeats", obs0.size() - base, 3);

    // Asynchronous reset during beat 2 of the full vector.
    base = obs0.size();
    send0(32'hFFFFFFFF, 32'hFFFFFFFF);
    in_valid0 = 1'b0;
    wait_obs0(base + 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid0), 0);
    chk("arst_in_ready", int'(in_ready0), 1);
    chk("arst_out_cnt", int'(out_cnt0), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("arst_idle_valid", int'(out_valid0), 0);
    base = obs0.size(); d = done0;
    send0(32'h000000F5, 32'h00000034);
    in_valid0 = 1'b0;
    wait_done0(d + 1);
    chk("arst_next_nbeats", obs0.size() - base, 3);

    // Zero-match vector on the instance that suppresses empty beats.
    b1 = beats1;
    flg_act = 32'hFFFF0000; flg_wei = 32'h0000FFFF; in_valid1 = 1'b1; n = 0;
    do begin cyc(); n++; end while (!acc1 && n < 50);
    in_valid1 = 1'b0;
    chk("ne_accept", int'(acc1), 1);
    chk("ne_in_ready_scan", int'(in_ready1), 1);
    chk("ne_out_valid", int'(out_valid1), 0);
    repeat (4) cyc();
    chk("ne_no_beats", beats1 - b1, 0);
    flg_act = 32'h3; flg_wei = 32'h2; in_valid1 = 1'b1; n = 0;
    do begin cyc(); n++; end while (!acc1 && n < 50);
    in_valid1 = 1'b0;
    n = 0;
    while (beats1 - b1 < 1 && n < 50) begin cyc(); n++; end
    repeat (2) cyc();
    chk("ne_one_beat", beats1 - b1, 1);

    // Randomized traffic with random backpressure.
    target = done0 + NRAND; sent = 0; n = 0;
    while ((sent < NRAND || in_valid0 || done0 < target) && n < 20000) begin
      out_ready0 = ($urandom_range(0, 3) != 0);
      if (!in_valid0 && sent < NRAND && $urandom_range(0, 2) != 0) begin
        ra = $urandom; rw = $urandom;
        case ($urandom_range(0, 3))
          0: rw = rw & $urandom & $urandom;
          1: ra = ~rw;
          2: begin ra = ra | $urandom; rw = rw | $urandom; end
          default: ;
        endcase
        flg_act = ra; flg_wei = rw; in_valid0 = 1'b1; sent++;
      end
      cyc(); n++;
      if (acc0) in_valid0 = 1'b0;
    end
    out_ready0 = 1'b1;
    chk("rand_done", done0, target);
    repeat (3) cyc();
    chk("exp0_drained", exp0.size(), 0);
    chk("exp1_drained", exp1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
